// File: rtl/mealy_pattern_matcher.sv
// Serial bit-pattern detector: CHANNELS runtime-programmable WIDTH-bit patterns with
// don't-care masks, overlap/non-overlap modes, and saturating per-channel match counters.

module mealy_pm_channel #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             clear_counts,
  input  logic             fill_ok,
  input  logic [WIDTH-1:0] window,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             overlap_in,
  output logic             o,
  output logic [CNT_W-1:0] count
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] pattern, mask;
  logic             overlap;
  logic [CW-1:0]    cooldown;
  logic             hit;

  // Masked-off bits compare as equal; reset forces o low even with a stale config.
  always_comb begin
    hit = &((window ~^ pattern) | ~mask);
    o   = ~reset & enable & fill_ok & (|mask) & hit & (overlap | (cooldown == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern <= '0;
      mask    <= '0;
      overlap <= 1'b0;
    end else if (load) begin
      pattern <= pattern_in;
      mask    <= mask_in;
      overlap <= overlap_in;
    end
  end

  // After a non-overlapping match, block the next WIDTH-1 accepted bits so
  // the following match is built only from fresh input.
  always_ff @(posedge clock) begin
    if (reset || load || overlap)
      cooldown <= '0;
    else if (o)
      cooldown <= CW'(WIDTH-1);
    else if (enable && cooldown != '0)
      cooldown <= cooldown - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || clear_counts)
      count <= '0;
    else if (o && count != '1)
      count <= count + CNT_W'(1);
  end
endmodule

module mealy_pattern_matcher #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      i,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] pattern_in,
  input  logic [CHANNELS*WIDTH-1:0] mask_in,
  input  logic [CHANNELS-1:0]       overlap_in,
  input  logic                      clear_counts,
  output logic [CHANNELS-1:0]       o,
  output logic [CHANNELS*CNT_W-1:0] match_count
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-2:0] hist;
  logic [CW-1:0]    fill;
  logic             fill_ok;
  logic [WIDTH-1:0] window;

  // window[0] is the live bit, window[j] the bit accepted j enables ago.
  assign window  = {hist, i};
  assign fill_ok = (fill == CW'(WIDTH-1));

  always_ff @(posedge clock) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (enable) begin
      hist <= window[WIDTH-2:0];
      if (!fill_ok) fill <= fill + CW'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mealy_pm_channel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .load         (load),
      .clear_counts (clear_counts),
      .fill_ok      (fill_ok),
      .window       (window),
      .pattern_in   (pattern_in[c*WIDTH +: WIDTH]),
      .mask_in      (mask_in[c*WIDTH +: WIDTH]),
      .overlap_in   (overlap_in[c]),
      .o            (o[c]),
      .count        (match_count[c*CNT_W +: CNT_W])
    );
  end
endmodule
